// File: rtl/timer_pkg.sv
// Shared constants for the machine timer, also used by the LSU address decode and BSP headers.
package timer_pkg;

   localparam logic [31:0] TIMER_BASE_ADDR = 32'h4000_4000;

   localparam logic [1:0] MTIME_LO_OFF    = 2'd0;
   localparam logic [1:0] MTIME_HI_OFF    = 2'd1;
   localparam logic [1:0] MTIMECMP_LO_OFF = 2'd2;
   localparam logic [1:0] MTIMECMP_HI_OFF = 2'd3;

   localparam int unsigned TIMER_WIDTH = 64;
   localparam int unsigned WORD_WIDTH  = 32;
   localparam int unsigned LANE_COUNT  = WORD_WIDTH / 8;

   // Replace only the byte lanes selected by byte_en.
   function automatic logic [WORD_WIDTH-1:0] merge_bytes(
      input logic [WORD_WIDTH-1:0] old_word,
      input logic [WORD_WIDTH-1:0] new_word,
      input logic [LANE_COUNT-1:0] byte_en
   );
      logic [WORD_WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < int'(LANE_COUNT); i++) begin
         if (byte_en[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the core clock into mtime ticks; tick_c is high in the last cycle of each period.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tick_c
);

   localparam int unsigned CNT_WIDTH = 16;
   localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(PRESCALE - 1);

   logic [CNT_WIDTH-1:0] count;

   // Tick when the counter reaches the end of its period.
   assign tick_c = (count == LAST_COUNT);

   // Free-running 0..PRESCALE-1 counter; register writes never touch it.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (tick_c) begin
         count <= '0;
      end else begin
         count <= count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp with a registered level interrupt.
// Optional feature: define TIMER_PRESCALER_EN to advance mtime every PRESCALE cycles.
module machine_timer
   import timer_pkg::*;
#(
   parameter int unsigned PRESCALE       = 1,
   parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic [3:0]  byte_enable,
   input  logic        timer_write_enable,
   output logic [31:0] timer_read_data,
   output logic        timer_interrupt
);

   // Reject divide ratios the 16-bit counter cannot represent.
   if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
      $error("machine_timer: PRESCALE must be in 1..65535");
   end

   logic [TIMER_WIDTH-1:0] mtime;
   logic [TIMER_WIDTH-1:0] mtimecmp;
   logic [TIMER_WIDTH-1:0] mtime_nxt;
   logic [TIMER_WIDTH-1:0] mtimecmp_nxt;
   logic [1:0]             word_sel;
   logic                   tick;
   logic                   unused_addr;

   assign word_sel    = address[3:2];
   assign unused_addr = ^{address[31:4], address[1:0]};

`ifdef TIMER_PRESCALER_EN
   timer_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .tick_c (tick)
   );
`else
   assign tick = 1'b1;
`endif

   // Next-state for mtime/mtimecmp: low-word writes freeze counting, high-word writes drop the carry.
   always_comb begin
      mtime_nxt    = mtime;
      mtimecmp_nxt = mtimecmp;

      if (timer_write_enable && word_sel == MTIME_LO_OFF) begin
         mtime_nxt[31:0] = merge_bytes(mtime[31:0], write_data, byte_enable);
      end else if (timer_write_enable && word_sel == MTIME_HI_OFF) begin
         mtime_nxt[63:32] = merge_bytes(mtime[63:32], write_data, byte_enable);
         if (tick) begin
            mtime_nxt[31:0] = mtime[31:0] + 32'd1;
         end
      end else if (tick) begin
         mtime_nxt = mtime + 64'd1;
      end

      if (timer_write_enable && word_sel == MTIMECMP_LO_OFF) begin
         mtimecmp_nxt[31:0] = merge_bytes(mtimecmp[31:0], write_data, byte_enable);
      end
      if (timer_write_enable && word_sel == MTIMECMP_HI_OFF) begin
         mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], write_data, byte_enable);
      end
   end

   // Register update; interrupt compares the pre-edge register values.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime           <= '0;
         mtimecmp        <= MTIMECMP_RESET;
         timer_interrupt <= 1'b0;
      end else begin
         mtime           <= mtime_nxt;
         mtimecmp        <= mtimecmp_nxt;
         timer_interrupt <= (mtime >= mtimecmp);
      end
   end

   // Zero-latency read mux for the LSU load path.
   always_comb begin
      timer_read_data = '0;
      case (word_sel)
         MTIME_LO_OFF:    timer_read_data = mtime[31:0];
         MTIME_HI_OFF:    timer_read_data = mtime[63:32];
         MTIMECMP_LO_OFF: timer_read_data = mtimecmp[31:0];
         MTIMECMP_HI_OFF: timer_read_data = mtimecmp[63:32];
         default:         timer_read_data = '0;
      endcase
   end

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer; prescaler checks run when TIMER_PRESCALER_EN is defined.
module tb_machine_timer;
   import timer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [3:0]  byte_enable;
   logic        timer_write_enable;
   logic [31:0] timer_read_data;
   logic        timer_interrupt;

   int n_cmp = 0;
   int n_bad = 0;

   machine_timer #(
      .PRESCALE       (4),
      .MTIMECMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .address            (address),
      .write_data         (write_data),
      .byte_enable        (byte_enable),
      .timer_write_enable (timer_write_enable),
      .timer_read_data    (timer_read_data),
      .timer_interrupt    (timer_interrupt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] word, output logic [31:0] val);
      address = TIMER_BASE_ADDR | (32'(word) << 2);
      #1;
      val = timer_read_data;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      address            = addr;
      write_data         = data;
      byte_enable        = be;
      timer_write_enable = 1'b1;
      step();
      timer_write_enable = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   logic [31:0] v;
   logic [31:0] a_mtime_lo;
   logic [31:0] a_mtime_hi;
   logic [31:0] a_cmp_lo;
   logic [31:0] a_cmp_hi;

   initial begin
      a_mtime_lo = TIMER_BASE_ADDR | 32'h0;
      a_mtime_hi = TIMER_BASE_ADDR | 32'h4;
      a_cmp_lo   = TIMER_BASE_ADDR | 32'h8;
      a_cmp_hi   = TIMER_BASE_ADDR | 32'hC;

      rst                = 1'b1;
      address            = TIMER_BASE_ADDR;
      write_data         = '0;
      byte_enable        = '0;
      timer_write_enable = 1'b0;
      #1;
      do_reset();

`ifndef TIMER_PRESCALER_EN
      // Reset values
      rd(2'd0, v); check("rst_mtime_lo", 64'(v), 64'h0);
      rd(2'd2, v); check("rst_cmp_lo", 64'(v), 64'hFFFF_FFFF);
      rd(2'd3, v); check("rst_cmp_hi", 64'(v), 64'hFFFF_FFFF);
      check("rst_irq", 64'(timer_interrupt), 64'h0);

      // Free run 10 cycles, interrupt stays low
      for (int i = 0; i < 10; i++) begin
         step();
         check("run_irq", 64'(timer_interrupt), 64'h0);
      end
      rd(2'd0, v); check("run10_lo", 64'(v), 64'd10);
      rd(2'd1, v); check("run10_hi", 64'(v), 64'd0);

      // Compare at 0x20: interrupt follows mtime one cycle later
      wr(a_cmp_lo, 32'h20, 4'hF);
      wr(a_cmp_hi, 32'h0, 4'hF);
      rd(2'd2, v); check("cmp_lo", 64'(v), 64'h20);
      begin
         int budget = 100;
         rd(2'd0, v);
         while (v != 32'h20 && budget > 0) begin
            check("irq_below_cmp", 64'(timer_interrupt), 64'h0);
            step();
            budget--;
            rd(2'd0, v);
         end
         check("reach_0x20", 64'(v), 64'h20);
      end
      check("irq_at_match_cycle", 64'(timer_interrupt), 64'h0);
      step();
      check("irq_rise", 64'(timer_interrupt), 64'h1);
      wr(a_cmp_hi, 32'h1, 4'hF);
      check("irq_hold_same_edge", 64'(timer_interrupt), 64'h1);
      step();
      check("irq_drop", 64'(timer_interrupt), 64'h0);

      // Carry from low into high word
      wr(a_mtime_lo, 32'hFFFF_FFFE, 4'hF);
      wr(a_mtime_hi, 32'h0, 4'hF);
      rd(2'd0, v); check("carry_pre_lo", 64'(v), 64'hFFFF_FFFF);
      step();
      rd(2'd0, v); check("carry_lo", 64'(v), 64'h0);
      rd(2'd1, v); check("carry_hi", 64'(v), 64'h1);

      // High-word write discards the low-word carry
      wr(a_mtime_lo, 32'hFFFF_FFFF, 4'hF);
      wr(a_mtime_hi, 32'h5, 4'hF);
      rd(2'd0, v); check("discard_lo", 64'(v), 64'h0);
      rd(2'd1, v); check("discard_hi", 64'(v), 64'h5);

      // 64-bit wrap; unsigned compare sees all-ones >= 0x1_0000_0020
      wr(a_mtime_lo, 32'hFFFF_FFFE, 4'hF);
      wr(a_mtime_hi, 32'hFFFF_FFFF, 4'hF);
      rd(2'd0, v); check("allones_lo", 64'(v), 64'hFFFF_FFFF);
      rd(2'd1, v); check("allones_hi", 64'(v), 64'hFFFF_FFFF);
      step();
      rd(2'd0, v); check("wrap_lo", 64'(v), 64'h0);
      rd(2'd1, v); check("wrap_hi", 64'(v), 64'h0);
      check("wrap_irq", 64'(timer_interrupt), 64'h1);
      step();
      check("wrap_irq_clear", 64'(timer_interrupt), 64'h0);

      // Partial low-word write freezes the count for that cycle
      wr(a_mtime_lo, 32'h1122_3344, 4'hF);
      wr(a_mtime_lo, 32'h00CC_0000, 4'b0100);
      rd(2'd0, v); check("partial_mtime_lo", 64'(v), 64'h11CC_3344);

      // Store byte into mtimecmp lane 1
      wr(a_cmp_lo, 32'hFFFF_FFFF, 4'hF);
      wr(TIMER_BASE_ADDR | 32'h9, 32'h0000_AB00, 4'b0010);
      rd(2'd2, v); check("sb_cmp_lo", 64'(v), 64'hFFFF_ABFF);
      rd(2'd3, v); check("sb_cmp_hi", 64'(v), 64'h1);

      // Reset wins over a concurrent mtime write
      wr(a_cmp_lo, 32'h0, 4'hF);
      wr(a_cmp_hi, 32'h0, 4'hF);
      wr(a_mtime_lo, 32'h1234, 4'hF);
      check("pre_rst_irq", 64'(timer_interrupt), 64'h1);
      address            = a_mtime_lo;
      write_data         = 32'h55;
      byte_enable        = 4'hF;
      timer_write_enable = 1'b1;
      rst                = 1'b1;
      #1;
      check("rst_reads_old", 64'(timer_read_data), 64'h1234);
      step();
      rst                = 1'b0;
      timer_write_enable = 1'b0;
      rd(2'd0, v); check("rstw_mtime_lo", 64'(v), 64'h0);
      rd(2'd1, v); check("rstw_mtime_hi", 64'(v), 64'h0);
      rd(2'd2, v); check("rstw_cmp_lo", 64'(v), 64'hFFFF_FFFF);
      rd(2'd3, v); check("rstw_cmp_hi", 64'(v), 64'hFFFF_FFFF);
      check("rstw_irq", 64'(timer_interrupt), 64'h0);
`else
      // PRESCALE=4: ticks at edges 4, 8, 12, 16 after reset
      rd(2'd0, v); check("ps_rst_lo", 64'(v), 64'h0);
      for (int i = 0; i < 3; i++) step();
      rd(2'd0, v); check("ps_edge3", 64'(v), 64'd0);
      step();
      rd(2'd0, v); check("ps_edge4", 64'(v), 64'd1);
      for (int i = 0; i < 12; i++) step();
      rd(2'd0, v); check("ps_edge16", 64'(v), 64'd4);
      check("ps_irq", 64'(timer_interrupt), 64'h0);

      // Write at edge 8 (a tick cycle) suppresses that tick but not the phase
      do_reset();
      for (int i = 0; i < 7; i++) step();
      rd(2'd0, v); check("ps_edge7", 64'(v), 64'd1);
      wr(a_mtime_lo, 32'h0, 4'hF);
      rd(2'd0, v); check("ps_wr_edge8", 64'(v), 64'd0);
      for (int i = 0; i < 3; i++) step();
      rd(2'd0, v); check("ps_edge11", 64'(v), 64'd0);
      step();
      rd(2'd0, v); check("ps_edge12", 64'(v), 64'd1);
      for (int i = 0; i < 4; i++) step();
      rd(2'd0, v); check("ps_edge16_phase", 64'(v), 64'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
